// File: rtl/axis_block_sig_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_block_pkg
// Shared types and helpers for the AXI-Stream stall detector.
//   blk_state_t : per-channel FSM state {IDLE, WAIT, BLOCKED}
//   wait_cond   : one-sided wait condition of a stream, by direction
//   sat_inc     : saturating increment (value and ceiling up to 32 bits)
// -----------------------------------------------------------------------------
package axis_block_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      BLOCKED = 2'd2
   } blk_state_t;

   // Input streams stall when the DUT is ready but starved; output streams
   // stall when the DUT offers data nobody accepts.
   function automatic logic wait_cond(input logic valid, input logic ready, input logic is_in);
      return is_in ? (ready && !valid) : (valid && !ready);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? max_value : value + 32'd1;
   endfunction

endpackage

// File: rtl/axis_block_sig_gen_if.sv
// -----------------------------------------------------------------------------
// axis_block_sig_gen_if
// TVALID/TREADY pairs of all monitored stream channels.
//   ch_valid : TVALID per channel
//   ch_ready : TREADY per channel
//   master   : the side driving the handshake (transactors)
//   slave    : the observer (stall detector)
// -----------------------------------------------------------------------------
interface axis_block_sig_gen_if #(
   parameter int NUM_CH = 3
);
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH-1:0] ch_ready;

   modport master (output ch_valid, output ch_ready);
   modport slave  (input ch_valid, input ch_ready);
endinterface

// File: rtl/axis_block_sig_gen_ch.sv
// -----------------------------------------------------------------------------
// axis_block_ch
// One channel's stall FSM (IDLE/WAIT/BLOCKED) with its saturating wait counter.
//   clock, reset   : clock, synchronous active-high reset
//   clear          : soft clear, same effect as reset
//   valid, ready   : channel handshake
//   blocked        : registered blocked flag
//   blocked_next   : flag value for the next cycle (for the top's OR)
//   cnt_next       : counter value for the next cycle (for the top's max)
// Optional (AXIS_BLOCK_STATS_EN): hs_cnt (handshakes, 32b saturating),
// blocked_evt (BLOCKED entries, 16b saturating).
// -----------------------------------------------------------------------------
module axis_block_ch
   import axis_block_pkg::*;
#(
   parameter int   STALL_THRESH = 16,
   parameter int   CNT_W        = 16,
   parameter logic IS_IN        = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             valid,
   input  logic             ready,
   output logic             blocked,
   output logic             blocked_next,
   output logic [CNT_W-1:0] cnt_next
`ifdef AXIS_BLOCK_STATS_EN
   ,
   output logic [31:0]      hs_cnt,
   output logic [15:0]      blocked_evt
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONES = '1;

   blk_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_inc;
   logic             waiting;

   assign waiting = wait_cond(valid, ready, IS_IN);
   assign cnt_inc = CNT_W'(sat_inc(32'(cnt_reg), 32'(CNT_ONES)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Clear is folded in here so the next-state flag and counter seen by the
   // top-level reductions already reflect it.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (clear) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (waiting) begin
                  cnt_next   = CNT_W'(1);
                  state_next = (STALL_THRESH == 1) ? BLOCKED : WAIT;
               end
            end
            WAIT: begin
               if (waiting) begin
                  cnt_next = cnt_inc;
                  if ((32'(cnt_reg) + 32'd1) == 32'(STALL_THRESH))
                     state_next = BLOCKED;
               end else begin
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end
            BLOCKED: begin
               if (waiting) begin
                  cnt_next = cnt_inc;
               end else begin
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end
            default: begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         endcase
      end
   end

   assign blocked      = (state_reg == BLOCKED);
   assign blocked_next = (state_next == BLOCKED);

`ifdef AXIS_BLOCK_STATS_EN
   logic [31:0] hs_cnt_reg;
   logic [15:0] blocked_evt_reg;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         hs_cnt_reg      <= '0;
         blocked_evt_reg <= '0;
      end else begin
         if (valid && ready)
            hs_cnt_reg <= sat_inc(hs_cnt_reg, 32'hFFFF_FFFF);
         if ((state_reg != BLOCKED) && (state_next == BLOCKED))
            blocked_evt_reg <= 16'(sat_inc(32'(blocked_evt_reg), 32'h0000_FFFF));
      end
   end

   assign hs_cnt      = hs_cnt_reg;
   assign blocked_evt = blocked_evt_reg;
`endif

endmodule

// File: rtl/axis_block_sig_gen.sv
// -----------------------------------------------------------------------------
// axis_block_sig_gen
// Per-channel AXI-Stream stall detector feeding the deadlock monitors.
//   clock, reset    : clock, synchronous active-high reset
//   clear           : soft clear of all counters and states
//   bus (slave)     : ch_valid / ch_ready of every channel
//   axis_block_sigs : registered per-channel blocked flags
//   block_any       : registered OR of the flags (same latency)
//   stall_cnt_max   : longest wait run seen since reset/clear, saturating
// Optional macro AXIS_BLOCK_STATS_EN adds hs_cnt and blocked_evt outputs.
// -----------------------------------------------------------------------------
module axis_block_sig_gen
   import axis_block_pkg::*;
#(
   parameter int                NUM_CH       = 3,
   parameter int                STALL_THRESH = 16,
   parameter int                CNT_W        = 16,
   parameter logic [NUM_CH-1:0] CH_IS_IN     = 3'b011
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   axis_block_sig_gen_if.slave          bus,
   output logic [NUM_CH-1:0]            axis_block_sigs,
   output logic                         block_any,
   output logic [CNT_W-1:0]             stall_cnt_max
`ifdef AXIS_BLOCK_STATS_EN
   ,
   output logic [NUM_CH-1:0][31:0]      hs_cnt,
   output logic [NUM_CH-1:0][15:0]      blocked_evt
`endif
);

   logic [NUM_CH-1:0] blocked_next;
   logic [CNT_W-1:0]  cnt_next [NUM_CH];
   logic [CNT_W-1:0]  stall_cnt_max_reg, stall_cnt_max_next;
   logic              block_any_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         axis_block_ch #(
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W),
            .IS_IN        (CH_IS_IN[gi])
         ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .clear        (clear),
            .valid        (bus.ch_valid[gi]),
            .ready        (bus.ch_ready[gi]),
            .blocked      (axis_block_sigs[gi]),
            .blocked_next (blocked_next[gi]),
            .cnt_next     (cnt_next[gi])
`ifdef AXIS_BLOCK_STATS_EN
            ,
            .hs_cnt       (hs_cnt[gi]),
            .blocked_evt  (blocked_evt[gi])
`endif
         );
      end
   endgenerate

   // Running maximum over the counters' next values, so a run's length is
   // captured in the same cycle the counter reaches it.
   always_comb begin
      stall_cnt_max_next = stall_cnt_max_reg;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_next[i] > stall_cnt_max_next)
            stall_cnt_max_next = cnt_next[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         block_any_reg     <= 1'b0;
         stall_cnt_max_reg <= '0;
      end else begin
         block_any_reg     <= |blocked_next;
         stall_cnt_max_reg <= stall_cnt_max_next;
      end
   end

   assign block_any     = block_any_reg;
   assign stall_cnt_max = stall_cnt_max_reg;

endmodule
